// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared types, constants and helpers for the mux select sequencer
//
// Purpose : state encoding, channel-count constants and the lowest-enabled-
//           channel helper used by mux_sel_sequencer and rr_next_sel.
// Ports   : none (package).

package mux_seq_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  // Lowest-index enabled channel; returns 0 for an empty mask (callers
  // never start a scan with an empty mask).
  function automatic logic [SEL_W-1:0] first_enabled(input logic [NCH-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = SEL_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_rr_next_sel.sv
// rtl/mux_sel_sequencer_rr_next_sel.sv - round-robin next enabled channel finder
//
// Purpose : given the current channel and the enable mask, find the next
//           enabled channel of higher index, wrapping past the top channel.
// Ports   : i_cur   - current channel index
//           i_mask  - channel enable mask (bit i = channel i)
//           o_next  - next enabled channel index
//           o_wrap  - next index is <= current index (pass complete)

module rr_next_sel
  import mux_seq_pkg::*;
(
  input  logic [SEL_W-1:0] i_cur,
  input  logic [NCH-1:0]   i_mask,
  output logic [SEL_W-1:0] o_next,
  output logic             o_wrap
);

  logic             w_found;
  logic [SEL_W-1:0] w_cand;

  // Search offsets 1..NCH so the current channel itself is the last
  // candidate; a single-channel mask therefore returns the same index and
  // is reported as a wrap. The 2-bit add wraps 3 -> 0 naturally.
  always_comb begin
    o_next  = i_cur;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_cand = i_cur + SEL_W'(k);
      if (!w_found && i_mask[w_cand]) begin
        o_next  = w_cand;
        w_found = 1'b1;
      end
    end
    o_wrap = (o_next <= i_cur);
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - round-robin select sequencer for a 2-bit 4:1 channel mux
//
// Purpose : steps the mux selects through the enabled channels, holding each
//           for a programmable dwell and strobing on its last dwell cycle.
//           Supports one-shot and continuous scans; all outputs registered.
// Ports   : clk           - system clock
//           rst_n         - synchronous active-low reset
//           start         - scan request, sampled in IDLE
//           stop          - scan abort, sampled in DWELL
//           one_shot      - 1 = single pass, 0 = continuous (latched at start)
//           ch_mask       - channel enables (latched at start)
//           dwell         - cycles per channel, 0 means 1 (latched at start)
//           s1, s0        - mux select MSB/LSB
//           sel_valid     - selects belong to an active scan
//           sample_strobe - pulse on the last dwell cycle of a channel
//           busy          - scan in progress
//           done          - pulse when a one-shot pass completes

module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               one_shot,
  input  logic [NCH-1:0]     ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               s1,
  output logic               s0,
  output logic               sel_valid,
  output logic               sample_strobe,
  output logic               busy,
  output logic               done
);

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [DWELL_W-1:0] r_cnt;
  logic [NCH-1:0]     r_mask;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_one_shot;
  logic               r_sel_valid;
  logic               r_strobe;
  logic               r_busy;
  logic               r_done;

  logic [DWELL_W-1:0] w_dwell_eff;
  logic [DWELL_W-1:0] w_dwell_m1;
  logic [DWELL_W-1:0] w_cnt_inc;
  logic               w_last;
  logic               w_start_ok;
  logic [SEL_W-1:0]   w_next_sel;
  logic               w_wrap;

  assign w_dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;
  assign w_dwell_m1  = r_dwell - DWELL_ONE;
  assign w_cnt_inc   = r_cnt + DWELL_ONE;
  assign w_last      = (r_cnt == w_dwell_m1);
  assign w_start_ok  = start && !stop && (ch_mask != '0);

  rr_next_sel u_rr_next_sel (
    .i_cur  (r_sel),
    .i_mask (r_mask),
    .o_next (w_next_sel),
    .o_wrap (w_wrap)
  );

  // The strobe is registered, so it is computed from the counter value the
  // next cycle will show: it lines up with the cycle where counter equals
  // dwell-1, including the dwell=1 case where every cycle is the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_dwell     <= DWELL_ONE;
      r_one_shot  <= 1'b0;
      r_sel_valid <= 1'b0;
      r_strobe    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_strobe <= 1'b0;
          if (w_start_ok) begin
            r_state     <= DWELL;
            r_mask      <= ch_mask;
            r_dwell     <= w_dwell_eff;
            r_one_shot  <= one_shot;
            r_sel       <= first_enabled(ch_mask);
            r_cnt       <= '0;
            r_sel_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_strobe    <= (w_dwell_eff == DWELL_ONE);
          end
        end

        DWELL: begin
          if (stop) begin
            // Abort wins over any coincident advance; selects hold.
            r_state     <= IDLE;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_strobe    <= 1'b0;
          end else if (w_last) begin
            if (w_wrap && r_one_shot) begin
              r_state     <= IDLE;
              r_sel_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_strobe    <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_sel    <= w_next_sel;
              r_cnt    <= '0;
              r_strobe <= (r_dwell == DWELL_ONE);
            end
          end else begin
            r_cnt    <= w_cnt_inc;
            r_strobe <= (w_cnt_inc == w_dwell_m1);
          end
        end

        default: begin
          r_state     <= IDLE;
          r_sel_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_strobe    <= 1'b0;
        end
      endcase
    end
  end

  assign s1            = r_sel[1];
  assign s0            = r_sel[0];
  assign sel_valid     = r_sel_valid;
  assign sample_strobe = r_strobe;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - self-checking bench for mux_sel_sequencer

module tb_mux_sel_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          one_shot;
  logic [3:0]    ch_mask;
  logic [DW-1:0] dwell;
  logic          s1, s0, sel_valid, sample_strobe, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected per-cycle output vector {sel[1:0], strobe, sel_valid, busy, done};
  // exp_q[c-1] is the cycle c clocks after start was driven.
  logic [5:0] exp_q[$];

  mux_sel_sequencer #(.DWELL_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .one_shot      (one_shot),
    .ch_mask       (ch_mask),
    .dwell         (dwell),
    .s1            (s1),
    .s0            (s0),
    .sel_valid     (sel_valid),
    .sample_strobe (sample_strobe),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {s1, s0, sample_strobe, sel_valid, busy, done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] m, input int d, input bit os);
    ch_mask  = m;
    dwell    = DW'(d);
    one_shot = os;
    stop     = 1'b0;
    start    = 1'b1;
  endtask

  // Pass-oriented model: list the enabled channels, emit each one dwell
  // times with the strobe on its last repetition, then either loop or emit
  // one done cycle followed by idle cycles holding the last channel.
  task automatic model_scan(input logic [3:0] m, input int d, input bit os, input int n);
    int         de;
    int         chans[$];
    int         idx;
    int         rep;
    bit         active;
    bit         pend;
    logic [1:0] last;
    de     = (d == 0) ? 1 : d;
    idx    = 0;
    rep    = 0;
    active = 1'b1;
    pend   = 1'b0;
    last   = 2'b00;
    for (int i = 0; i < 4; i++) if (m[i]) chans.push_back(i);
    for (int c = 0; c < n; c++) begin
      if (active) begin
        last = 2'(chans[idx]);
        exp_q.push_back({last, (rep == de - 1), 1'b1, 1'b1, 1'b0});
        rep++;
        if (rep == de) begin
          rep = 0;
          idx++;
          if (idx == chans.size()) begin
            idx = 0;
            if (os) begin
              active = 1'b0;
              pend   = 1'b1;
            end
          end
        end
      end else begin
        exp_q.push_back({last, 1'b0, 1'b0, 1'b0, pend});
        pend = 1'b0;
      end
    end
  endtask

  // Stop sampled at the end of cycle k: keep cycles 1..k, then idle with
  // the selects frozen, until the trace is n cycles long.
  task automatic model_stop(input int k, input int n);
    logic [1:0] hold;
    while (exp_q.size() > k) void'(exp_q.pop_back());
    hold = exp_q[k-1][5:4];
    while (exp_q.size() < n) exp_q.push_back({hold, 4'b0000});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; one_shot = 1'b1;
    ch_mask = 4'hf; dwell = DW'(7);
    step();
    step();
    n_cmp++;
    if (obs() !== 6'b000000) begin
      n_bad++;
      $display("FAIL reset_state: got %b expected %b", obs(), 6'b000000);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (obs() !== 6'b000000) begin
      n_bad++;
      $display("FAIL reset_release: got %b expected %b", obs(), 6'b000000);
    end
  endtask

  task automatic test_ignored_start();
    launch(4'b0000, 3, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      step();
      start = 1'b0;
      n_cmp++;
      if (obs() !== 6'b000000) begin
        n_bad++;
        $display("FAIL ignored_empty_mask cycle %0d: got %b expected %b", c, obs(), 6'b000000);
      end
    end
    launch(4'b1111, 3, 1'b1);
    stop = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      start = 1'b0;
      stop  = 1'b0;
      n_cmp++;
      if (obs() !== 6'b000000) begin
        n_bad++;
        $display("FAIL ignored_start_stop cycle %0d: got %b expected %b", c, obs(), 6'b000000);
      end
    end
  endtask

  task automatic test_one_shot();
    exp_q.delete();
    model_scan(4'b1111, 3, 1'b1, 16);
    launch(4'b1111, 3, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) start = 1'b0;
      n_cmp++;
      if (obs() !== exp_q[c-1]) begin
        n_bad++;
        $display("FAIL one_shot cycle %0d: got %b expected %b", c, obs(), exp_q[c-1]);
      end
    end
  endtask

  task automatic test_continuous();
    logic [5:0] exp_idle;
    exp_q.delete();
    model_scan(4'b1010, 2, 1'b0, 20);
    launch(4'b1010, 2, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) start = 1'b0;
      n_cmp++;
      if (obs() !== exp_q[c-1]) begin
        n_bad++;
        $display("FAIL continuous cycle %0d: got %b expected %b", c, obs(), exp_q[c-1]);
      end
    end
    exp_idle = {exp_q[19][5:4], 4'b0000};
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++;
    if (obs() !== exp_idle) begin
      n_bad++;
      $display("FAIL continuous_stop: got %b expected %b", obs(), exp_idle);
    end
  endtask

  task automatic test_stop();
    exp_q.delete();
    model_scan(4'b1111, 4, 1'b0, 10);
    model_stop(10, 14);
    launch(4'b1111, 4, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) start = 1'b0;
      stop = (c == 10);
      n_cmp++;
      if (obs() !== exp_q[c-1]) begin
        n_bad++;
        $display("FAIL stop_mid_channel cycle %0d: got %b expected %b", c, obs(), exp_q[c-1]);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_dwell_zero();
    exp_q.delete();
    model_scan(4'b0100, 0, 1'b1, 4);
    launch(4'b0100, 0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) start = 1'b0;
      n_cmp++;
      if (obs() !== exp_q[c-1]) begin
        n_bad++;
        $display("FAIL dwell_zero cycle %0d: got %b expected %b", c, obs(), exp_q[c-1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    model_scan(4'b0011, 1, 1'b1, 3);
    model_scan(4'b1000, 2, 1'b1, 6);
    launch(4'b0011, 1, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1 || c == 4) start = 1'b0;
      if (c == 3) launch(4'b1000, 2, 1'b1);
      n_cmp++;
      if (obs() !== exp_q[c-1]) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs(), exp_q[c-1]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    exp_q.delete();
    model_scan(4'b1111, 5, 1'b0, 8);
    launch(4'b1111, 5, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) start = 1'b0;
      n_cmp++;
      if (obs() !== exp_q[c-1]) begin
        n_bad++;
        $display("FAIL pre_reset cycle %0d: got %b expected %b", c, obs(), exp_q[c-1]);
      end
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if (obs() !== 6'b000000) begin
      n_bad++;
      $display("FAIL mid_scan_reset: got %b expected %b", obs(), 6'b000000);
    end
    exp_q.delete();
    model_scan(4'b1111, 5, 1'b0, 12);
    model_stop(12, 13);
    launch(4'b1111, 5, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 1) start = 1'b0;
      stop = (c == 12);
      n_cmp++;
      if (obs() !== exp_q[c-1]) begin
        n_bad++;
        $display("FAIL post_reset_scan cycle %0d: got %b expected %b", c, obs(), exp_q[c-1]);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] m;
    int         d;
    bit         os;
    int         nen;
    int         len;
    int         stop_at;
    for (int it = 0; it < 40; it++) begin
      m   = 4'($urandom_range(1, 15));
      d   = $urandom_range(0, 5);
      os  = 1'($urandom_range(0, 1));
      nen = 0;
      for (int i = 0; i < 4; i++) if (m[i]) nen++;
      if (os) begin
        len     = nen * ((d == 0) ? 1 : d) + 3;
        stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len - 3) : 0;
      end else begin
        len     = $urandom_range(6, 30);
        stop_at = len - 2;
      end
      exp_q.delete();
      model_scan(m, d, os, len);
      if (stop_at > 0) model_stop(stop_at, len);
      launch(m, d, os);
      for (int c = 1; c <= len; c++) begin
        step();
        n_cmp++;
        if (obs() !== exp_q[c-1]) begin
          n_bad++;
          $display("FAIL random it %0d cycle %0d (mask %b dwell %0d os %0d): got %b expected %b",
                   it, c, m, d, os, obs(), exp_q[c-1]);
        end
        // While a scan is running, new start and parameter values must be ignored.
        if (exp_q[c-1][1]) begin
          start    = 1'($urandom_range(0, 1));
          ch_mask  = 4'($urandom);
          dwell    = DW'($urandom);
          one_shot = 1'($urandom_range(0, 1));
        end else begin
          start = 1'b0;
        end
        stop = (c == stop_at);
      end
      start = 1'b0;
      stop  = 1'b0;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    one_shot = 1'b0;
    ch_mask  = 4'b0000;
    dwell    = '0;
    test_reset();
    test_ignored_start();
    test_one_shot();
    test_continuous();
    test_stop();
    test_dwell_zero();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
